// File: rtl/strobe_divider_chain.sv
// rtl/strobe_divider_chain.sv - cascaded programmable enable-strobe divider with burst mode
module strobe_divider_chain #(
  parameter int NUM_STAGES    = 3,
  parameter int CNT_W         = 5,
  parameter int BURST_W       = 8,
  parameter int DEFAULT_LIMIT = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        en_in,
  input  logic                        load,
  input  logic [NUM_STAGES*CNT_W-1:0] div_limit,
  input  logic                        mode,
  input  logic                        start,
  input  logic [BURST_W-1:0]          burst_len,
  output logic [NUM_STAGES-1:0]       strobe_out,
  output logic [NUM_STAGES*CNT_W-1:0] count,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_n;
  logic [BURST_W-1:0]   remaining, remaining_n;
  logic                 done_n;
  logic                 clr_cnt;
  logic                 act;
  logic                 last_fire;
  logic [CNT_W-1:0]     cnt [NUM_STAGES];
  logic [CNT_W-1:0]     lim [NUM_STAGES];
  logic [NUM_STAGES-1:0] tick;
  logic [NUM_STAGES-1:0] wrap;

  // Global gate: in burst mode the chain only advances while a burst is running.
  assign act = en & (~mode | (state == RUN));

  // Ripple the tick down the chain; each stage wraps when it sees a tick at its limit.
  always_comb begin
    logic t;
    t    = act & en_in;
    tick = '0;
    wrap = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      tick[k] = t;
      wrap[k] = t & (cnt[k] == lim[k]);
      t       = wrap[k];
    end
  end

  // Strobes are zero-latency copies of the wraps, hidden during load and reset.
  assign strobe_out = wrap & ~{NUM_STAGES{load | reset}};
  assign last_fire  = strobe_out[NUM_STAGES-1];

  // Expose counters packed the same way as div_limit.
  always_comb begin
    count = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      count[k*CNT_W +: CNT_W] = cnt[k];
    end
  end

  // Limit shadow registers, replaced wholesale on load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) lim[k] <= CNT_W'(DEFAULT_LIMIT);
    end else if (load) begin
      for (int k = 0; k < NUM_STAGES; k++) lim[k] <= div_limit[k*CNT_W +: CNT_W];
    end
  end

  // Stage counters: cleared by load or burst start, otherwise count ticks modulo limit+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) cnt[k] <= '0;
    end else if (load || clr_cnt) begin
      for (int k = 0; k < NUM_STAGES; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (tick[k]) cnt[k] <= wrap[k] ? '0 : cnt[k] + CNT_W'(1);
      end
    end
  end

  // Burst FSM state, remaining count and done pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      done      <= done_n;
    end
  end

  // Burst FSM next state: start loads the length, final-stage strobes count it down.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    done_n      = 1'b0;
    clr_cnt     = 1'b0;
    case (state)
      IDLE: begin
        if (mode && start) begin
          clr_cnt     = 1'b1;
          remaining_n = burst_len;
          if (burst_len == '0) done_n = 1'b1;
          else                 state_n = RUN;
        end
      end
      RUN: begin
        if (!mode) begin
          state_n = IDLE;
        end else if (last_fire) begin
          remaining_n = remaining - BURST_W'(1);
          if (remaining == BURST_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_strobe_divider_chain.sv
// tb/tb_strobe_divider_chain.sv - self-checking bench for strobe_divider_chain
module tb_strobe_divider_chain;

  localparam int NS = 3;
  localparam int CW = 5;
  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b1;
  logic            en_in = 1'b0;
  logic            load = 1'b0;
  logic [NS*CW-1:0] div_limit = '0;
  logic            mode = 1'b0;
  logic            start = 1'b0;
  logic [BW-1:0]   burst_len = '0;
  logic [NS-1:0]   strobe_out;
  logic [NS*CW-1:0] count;
  logic            busy;
  logic            done;

  int n_chk = 0;
  int n_fail = 0;

  strobe_divider_chain #(.NUM_STAGES(NS), .CNT_W(CW), .BURST_W(BW), .DEFAULT_LIMIT(7)) dut (
    .clk(clk), .reset(reset), .en(en), .en_in(en_in), .load(load),
    .div_limit(div_limit), .mode(mode), .start(start), .burst_len(burst_len),
    .strobe_out(strobe_out), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the chain is a mixed-radix counter of accepted ticks since the last clear.
  int m_n = 0;
  int m_lim [NS] = '{7, 7, 7};
  int m_rem = 0;
  bit m_run = 0;
  bit m_done = 0;

  function automatic int pprod(input int k);
    int p;
    p = 1;
    for (int j = 0; j < k; j++) p = p * (m_lim[j] + 1);
    return p;
  endfunction

  always @(negedge clk) begin
    logic [NS*CW-1:0] e_cnt;
    logic [NS-1:0]    e_str;
    bit acc;
    bit fire;
    if (reset) begin
      m_n = 0; m_rem = 0; m_run = 0; m_done = 0;
      for (int k = 0; k < NS; k++) m_lim[k] = 7;
      chk("rst_strobe", strobe_out, 0);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end else begin
      acc = en && (!mode || m_run) && en_in;
      for (int k = 0; k < NS; k++) begin
        e_cnt[k*CW +: CW] = CW'((m_n / pprod(k)) % (m_lim[k] + 1));
        e_str[k] = acc && !load && (((m_n + 1) % pprod(k + 1)) == 0);
      end
      chk("strobe_out", strobe_out, e_str);
      chk("count", count, e_cnt);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      fire = e_str[NS-1];
      if (acc) m_n = (m_n + 1) % pprod(NS);
      m_done = 0;
      if (!m_run) begin
        if (mode && start) begin
          m_n = 0;
          m_rem = int'(burst_len);
          if (burst_len == 0) m_done = 1;
          else m_run = 1;
        end
      end else if (!mode) begin
        m_run = 0;
      end else if (fire) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_run = 0;
          m_done = 1;
        end
      end
      if (load) begin
        m_n = 0;
        for (int k = 0; k < NS; k++) m_lim[k] = int'(div_limit[k*CW +: CW]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, c1, c2, first0, firstp, lastp, dcnt, sgap, bseen;
    logic [NS*CW-1:0] frozen;

    step(); step();
    #2;
    chk("reset_count_lit", count, 0);
    chk("reset_busy_lit", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Default limits: divide by 8 per stage.
    en_in = 1'b1;
    c0 = 0; c1 = 0; c2 = 0; first0 = -1;
    for (int i = 0; i < 512; i++) begin
      #2;
      if (strobe_out[0]) begin c0++; if (first0 < 0) first0 = i; end
      if (strobe_out[1]) c1++;
      if (strobe_out[2]) begin c2++; chk("coincide", strobe_out, 3'b111); end
      @(posedge clk); #1;
    end
    chk("t1_first0", first0, 7);
    chk("t1_c0", c0, 64);
    chk("t1_c1", c1, 8);
    chk("t1_c2", c2, 1);

    // Limits {2,0,4}.
    en_in = 1'b0; load = 1'b1; div_limit = {5'd2, 5'd0, 5'd4};
    step();
    load = 1'b0; en_in = 1'b1;
    #2;
    chk("t2_cleared", count, 0);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) #2;
      if (strobe_out[0]) c0++;
      if (strobe_out[1]) c1++;
      if (strobe_out[2]) c2++;
      @(posedge clk); #1;
    end
    chk("t2_c0", c0, 6);
    chk("t2_c1", c1, 6);
    chk("t2_c2", c2, 2);

    // Sparse en_in with an en gap.
    sgap = 0;
    frozen = '0;
    for (int i = 0; i < 60; i++) begin
      en = !(i >= 20 && i < 40);
      en_in = (i % 4 == 0);
      #2;
      if (i == 20) frozen = count;
      if (i >= 20 && i < 40 && strobe_out != 0) sgap++;
      if (i == 40) chk("t3_frozen", count, frozen);
      @(posedge clk); #1;
    end
    chk("t3_gap_strobes", sgap, 0);
    en = 1'b1;

    // Burst of 3 with all limits 1.
    en_in = 1'b0; load = 1'b1; div_limit = {5'd1, 5'd1, 5'd1};
    step();
    load = 1'b0;
    mode = 1'b1; start = 1'b1; burst_len = 8'd3; en_in = 1'b1;
    #2;
    chk("t4_busy_pre", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    c2 = 0; dcnt = 0; firstp = -1; lastp = -1;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (i == 0) chk("t4_busy_after_start", busy, 1);
      if (i == 24) chk("t4_done_at", done, 1);
      if (strobe_out[2]) begin c2++; if (firstp < 0) firstp = i; lastp = i; end
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("t4_pulses", c2, 3);
    chk("t4_spacing", lastp - firstp, 16);
    chk("t4_done_count", dcnt, 1);

    // Burst of length 0.
    start = 1'b1; burst_len = 8'd0;
    step();
    start = 1'b0;
    #2;
    chk("t5_done", done, 1);
    bseen = 0; c2 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) #2;
      if (busy) bseen++;
      if (strobe_out != 0) c2++;
      @(posedge clk); #1;
    end
    chk("t5_busy_never", bseen, 0);
    chk("t5_no_strobes", c2, 0);

    // Reset in the middle of a burst of 5 after 3 strobes.
    start = 1'b1; burst_len = 8'd5;
    step();
    start = 1'b0;
    c2 = 0;
    for (int i = 0; i < 24; i++) begin
      #2;
      if (strobe_out[2]) c2++;
      @(posedge clk); #1;
    end
    chk("t6_pulses_before_reset", c2, 3);
    chk("t6_busy_before_reset", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_strobe", strobe_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bseen = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (busy) bseen++;
      @(posedge clk); #1;
    end
    chk("t6_idle_after", bseen, 0);
    chk("t6_idle_count", count, 0);
    mode = 1'b0;
    first0 = -1;
    for (int i = 0; i < 16; i++) begin
      #2;
      if (strobe_out[0] && first0 < 0) first0 = i;
      @(posedge clk); #1;
    end
    chk("t6_default_limit", first0, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/strobe_divider_chain.md
Name: strobe_divider_chain

Overview:
- Parametrised cascaded enable-strobe divider; successor to the fixed two-stage 8 MHz to 1 MHz generator.
- NUM_STAGES counters in series. Each stage divides the strobe rate of the stage before it by (limit+1).
- Limits are programmable at runtime through shadow registers.
- Adds a burst mode: emits a set number of final-stage strobes, then stops and reports done.
- Sits between the master-clock prescaler and the photonic-switch timing logic.

Parameters:
- NUM_STAGES, 3, number of cascaded divider stages (min 1).
- CNT_W, 5, width of each stage counter and limit.
- BURST_W, 8, width of the burst-length counter.
- DEFAULT_LIMIT, 7, value loaded into every limit register at reset (divide by 8 per stage).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when low, counters hold and all strobes are 0.
- en_in  in  1  input strobe, one clk wide, that drives stage 0.
- load  in  1  pulse: latch div_limit into the limit registers and clear all counters.
- div_limit  in  NUM_STAGES*CNT_W  new limits; stage k uses bits [k*CNT_W +: CNT_W].
- mode  in  1  0 = free-run, 1 = burst.
- start  in  1  pulse: begin a burst (used only when mode=1).
- burst_len  in  BURST_W  number of final-stage strobes per burst; sampled on start.
- strobe_out  out  NUM_STAGES  per-stage wrap strobes; bit NUM_STAGES-1 is the slowest rate.
- count  out  NUM_STAGES*CNT_W  current counter values, packed the same way as div_limit.
- busy  out  1  high while the burst FSM is in RUN.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (async): all counters 0, limits = DEFAULT_LIMIT, FSM = IDLE, remaining = 0, busy = 0, done = 0. strobe_out = 0 while reset is high.
- Gating: act = en AND (mode=0 OR state=RUN).
- Stage tick chain:
  - tick[0] = act AND en_in.
  - wrap[k] = tick[k] AND (cnt[k] == lim[k]).
  - tick[k+1] = wrap[k].
- strobe_out[k] = wrap[k]. It is combinational, asserted in the same cycle as the en_in pulse that causes it (zero latency).
- Counter update on tick[k]: if cnt = lim, wrap to 0; otherwise increment. With no tick, the counter holds.
- Limit 0 means divide by 1: the stage passes every tick through and its counter stays 0.
- Overall ratio: final strobe = en_in rate / product over k of (lim[k]+1).
- load: on the next clk edge, lim <= div_limit and every cnt <= 0. strobe_out is suppressed in the load cycle. The FSM state and remaining count are not affected.
- Counters never exceed their limit, because load always clears them.
- Burst FSM, states IDLE and RUN:
  - IDLE with mode=1 and start: remaining <= burst_len, counters cleared, go to RUN.
  - Start with burst_len = 0: no RUN; done pulses on the next cycle.
  - RUN: each wrap[NUM_STAGES-1] decrements remaining. The wrap that takes remaining 1 to 0 is still output; on that edge go to IDLE and done pulses for one cycle.
  - start during RUN is ignored.
  - mode dropping to 0 during RUN: go to IDLE next edge, no done pulse, counters keep their values and continue in free-run.
  - In IDLE with mode=1, counters hold and strobe_out = 0.
- Simultaneous load and start in IDLE: both take effect. The new limits apply to the burst and counters are cleared.
- en low during RUN: the burst pauses and remaining holds.
- busy = (state == RUN), registered.

Test Plan:
- Reset defaults, NUM_STAGES=3, en=1, mode=0, en_in every cycle -> strobe_out[0] every 8 cycles, [1] every 64, [2] every 512. Each [2] pulse coincides with [1] and [0] in the same cycle.
- load with limits {2,0,4} (stage2, stage1, stage0) -> counters zeroed. Stage 0 fires every 5 en_in, stage 1 fires on every stage-0 wrap, stage 2 every 15 en_in.
- en_in every 4th cycle, toggle en low for 20 cycles mid-count -> count frozen during the gap. Strobe spacing resumes exactly where it stopped.
- mode=1, burst_len=3, start, limits all 1 -> exactly 3 strobe_out[2] pulses 8 en_in apart. busy high from the cycle after start; done for one cycle after the third pulse; no further strobes.
- mode=1, start with burst_len=0 -> done the next cycle, busy never set, no strobes.
- Assert reset mid-burst (remaining=2) -> busy, done, count and strobe_out go to 0 immediately. Limits return to 7; the FSM stays in IDLE after release.
